// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared definitions for carry-save consumers: FSM states, slice count, cout weight.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    // A carry-save carry vector bit i carries weight 2^(i+1).
    localparam int COUT_SHIFT = 1;

    function automatic int nslice(input int w, input int chunk);
        return (w + 2) / chunk;
    endfunction

endpackage

// File: rtl/csa_fa.sv
// rtl/csa_fa.sv - single-bit full adder cell.
module csa_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/csa_slice_add.sv
// rtl/csa_slice_add.sv - CHUNK-bit ripple-carry adder slice built from full adder cells.
module csa_slice_add #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        csa_fa u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/csa_resolve_seq.sv
// rtl/csa_resolve_seq.sv - resolves a carry-save (cout, sum) pair to binary, CHUNK bits per cycle.
module csa_resolve_seq
    import csa_pkg::*;
#(
    parameter int W     = 8,
    parameter int CHUNK = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   cs_sum,
    input  logic [W-1:0]   cs_cout,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+1:0]   result
);

    localparam int RW = W + 2;
    localparam int NS = nslice(W, CHUNK);
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    if ((RW % CHUNK) != 0) begin : g_bad_chunk
        $error("csa_resolve_seq: (W+2) must be a multiple of CHUNK");
    end

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [RW-1:0]   a_reg;
    logic [RW-1:0]   b_reg;
    logic [RW-1:0]   res_reg;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_sl;
    logic             last;

    assign last = (cnt == CW'(NS - 1));
    assign a_sl = a_reg[cnt*CHUNK +: CHUNK];
    assign b_sl = b_reg[cnt*CHUNK +: CHUNK];

    csa_slice_add #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .s    (s_sl),
        .cout (c_sl)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = ADD;
            ADD:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= RW'(cs_sum);
                        b_reg <= RW'(cs_cout) << COUT_SHIFT;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    res_reg[cnt*CHUNK +: CHUNK] <= s_sl;
                    carry                       <= c_sl;
                    cnt                         <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The operand widths leave headroom, so the top slice can never carry out.
    assert property (@(posedge clk) disable iff (rst) (state == ADD && last) |-> !c_sl);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_reg;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// tb/tb_csa_resolve_seq.sv - self-checking bench for csa_resolve_seq.
module tb_csa_resolve_seq;

    localparam int W     = 8;
    localparam int CHUNK = 2;
    localparam int NS    = (W + 2) / CHUNK;
    localparam int RW    = W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  cs_sum;
    logic [W-1:0]  cs_cout;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    csa_resolve_seq #(
        .W     (W),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cs_sum    (cs_sum),
        .cs_cout   (cs_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int golden(input int s, input int c);
        return s + 2 * c;
    endfunction

    task automatic send_and_wait(input logic [W-1:0] s, input logic [W-1:0] c, output int lat);
        int guard;
        cs_sum   = s;
        cs_cout  = c;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            step;
            guard++;
        end
        step;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            step;
            lat++;
        end
    endtask

    task automatic run_stream(input int n, input bit stall, input string tag);
        int q[$];
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int last = -1;
        int exp;
        bit fi;
        bit fo;
        cs_sum    = W'($urandom);
        cs_cout   = W'($urandom);
        in_valid  = 1'b1;
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        while (got < n && cyc < n * 40 + 100) begin
            fi = in_valid && in_ready;
            fo = out_valid && out_ready;
            if (fo) begin
                if (q.size() == 0) begin
                    check({tag, " spurious"}, 32'(out_valid), 32'(0));
                end else begin
                    exp = q.pop_front();
                    check({tag, " result"}, 32'(result), 32'(exp));
                    if (!stall && last >= 0)
                        check({tag, " period"}, cyc - last, NS + 2);
                    last = cyc;
                end
                got++;
            end
            if (fi) begin
                q.push_back(golden(int'(cs_sum), int'(cs_cout)));
                sent++;
            end
            step;
            cyc++;
            if (fi) begin
                cs_sum  = W'($urandom);
                cs_cout = W'($urandom);
            end
            if (stall) begin
                if (!in_valid || fi)
                    in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid = (sent < n);
            end
        end
        check({tag, " count"}, got, n);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step;
    endtask

    initial begin
        int lat;
        logic [RW-1:0] held;
        bit seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cs_sum    = '0;
        cs_cout   = '0;
        step;
        step;
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'(1));
        check("reset out_valid", 32'(out_valid), 32'(0));
        check("reset result", 32'(result), 32'(0));

        // Zero operands and first-result latency.
        send_and_wait(8'h00, 8'h00, lat);
        check("zero latency", lat, NS + 1);
        check("zero result", 32'(result), 32'(10'h000));
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check("zero accept", 32'(out_valid), 32'(0));

        // All ones: carry ripples through every slice.
        send_and_wait(8'hFF, 8'hFF, lat);
        check("ones latency", lat, NS + 1);
        check("ones result", 32'(result), 32'(golden(255, 255)));
        check("ones const", 32'(result), 32'(10'h2FD));
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;

        // Backpressure: DONE holds while out_ready stays low.
        send_and_wait(8'h5A, 8'h81, lat);
        check("bp result", 32'(result), 32'(10'h15C));
        held = result;
        for (int i = 0; i < 10; i++) begin
            cs_sum  = W'($urandom);
            cs_cout = W'($urandom);
            step;
            check("bp out_valid", 32'(out_valid), 32'(1));
            check("bp in_ready", 32'(in_ready), 32'(0));
            check("bp stable", 32'(result), 32'(held));
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check("bp accepted", 32'(out_valid), 32'(0));
        check("bp idle", 32'(in_ready), 32'(1));

        // Reset during the third ADD cycle discards the operation.
        cs_sum   = 8'h37;
        cs_cout  = 8'hC4;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("midrst in_ready", 32'(in_ready), 32'(1));
        check("midrst out_valid", 32'(out_valid), 32'(0));
        check("midrst result", 32'(result), 32'(0));
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("midrst no output", 32'(seen), 32'(0));

        // Back-to-back streaming, then random stalls on both sides.
        run_stream(6, 1'b0, "b2b");
        run_stream(2000, 1'b1, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
